// File: rtl/postproc.sv
// Output recombiner for the 2-parallel fast FIR: rebuilds Y0/Y1 from the three
// subfilter results and serializes them as one sample per cycle.
module postproc #(
  parameter int DWIDTH  = 16,
  parameter int DDWIDTH = 2 * DWIDTH,
  parameter int OWIDTH  = DDWIDTH + 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [0:DDWIDTH-1] y0_in,
  input  logic signed [0:DDWIDTH-1] y1_in,
  input  logic signed [0:DDWIDTH-1] y01_in,
  output logic                      out_valid,
  output logic signed [0:OWIDTH-1]  data_out,
  output logic                      out_phase
);

  if (DDWIDTH < 2 * DWIDTH || OWIDTH < DDWIDTH + 2) begin : g_width_guard
    $error("postproc: OWIDTH too narrow for exact recombination");
  end

  typedef enum logic [1:0] {IDLE, EMIT_EVEN, EMIT_ODD} state_e;

  state_e state_q, state_d;

  logic signed [OWIDTH-1:0] y1_dly_q;
  logic signed [OWIDTH-1:0] hold_y0_q;
  logic signed [OWIDTH-1:0] hold_y1_q;

  logic signed [OWIDTH-1:0] y0_ext, y1_ext, y01_ext;
  logic                     accept;

  // Bit 0 is the MSB of each input, so it is the sign bit to replicate.
  assign y0_ext  = {{(OWIDTH - DDWIDTH){y0_in[0]}},  y0_in};
  assign y1_ext  = {{(OWIDTH - DDWIDTH){y1_in[0]}},  y1_in};
  assign y01_ext = {{(OWIDTH - DDWIDTH){y01_in[0]}}, y01_in};

  assign accept = in_valid && in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: state_d gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (in_valid) state_d = EMIT_EVEN;
      EMIT_EVEN: state_d = EMIT_ODD;
      EMIT_ODD:  state_d = in_valid ? EMIT_EVEN : IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // The y1 delay advances per accepted block, not per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      y1_dly_q  <= '0;
      hold_y0_q <= '0;
      hold_y1_q <= '0;
    end else if (accept) begin
      y1_dly_q  <= y1_ext;
      hold_y0_q <= y0_ext + y1_dly_q;
      hold_y1_q <= y01_ext - y0_ext - y1_ext;
    end
  end

  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    out_phase = 1'b0;
    data_out  = hold_y1_q;
    unique case (state_q)
      EMIT_EVEN: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        data_out  = hold_y0_q;
      end
      EMIT_ODD: begin
        out_valid = 1'b1;
        out_phase = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/postproc.md
Name: postproc

Overview:
- Output-side recombiner for the 2-parallel fast FIR.
- Accepts one block of three subfilter results per handshake:
  - y0 = H0·X0
  - y1 = H1·X1
  - y01 = (H0+H1)·(X0+X1)
- Reconstructs the even and odd output samples (Y0, Y1) using a one-block delay on y1.
- Serializes them into one output sample per cycle. Sits after the subfilter array; mirrors the input-side splitter.

Parameters:
- DWIDTH, 16, input sample / coefficient width.
- DDWIDTH, 2*DWIDTH, width of each subfilter result.
- OWIDTH, DDWIDTH+2, width of the reconstructed output sample, sized so it never overflows.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  a y0/y1/y01 triple is presented.
- in_ready  output  1  the block can accept a triple this cycle.
- y0_in  input  signed [0:DDWIDTH-1]  H0 subfilter result.
- y1_in  input  signed [0:DDWIDTH-1]  H1 subfilter result.
- y01_in  input  signed [0:DDWIDTH-1]  (H0+H1) subfilter result.
- out_valid  output  1  data_out holds a valid sample.
- data_out  output  signed [0:OWIDTH-1]  serialized output stream: even sample, then odd sample.
- out_phase  output  1  0 = even sample (Y0), 1 = odd sample (Y1).

Behaviour:
- Bit 0 is the MSB on all vector ports. All arithmetic is two's complement. Inputs are sign-extended to OWIDTH before any add or subtract. No saturation and no truncation.
- Registers:
  - state: IDLE, EMIT_EVEN, EMIT_ODD.
  - y1_d: delayed y1, OWIDTH wide.
  - hold_y0, hold_y1: OWIDTH each.
- Reset (rst=1 at an edge):
  - state=IDLE; y1_d=0; hold_y0=0; hold_y1=0.
  - Outputs: out_valid=0, data_out=0, out_phase=0, in_ready=1.
  - Reset mid-emission discards the pending samples and the y1 history.
- in_ready is combinational from state: it is 0 only in EMIT_EVEN.
- Accept = in_valid && in_ready at a rising edge. On accept:
  - hold_y0 <= y0_in + y1_d
  - hold_y1 <= y01_in − y0_in − y1_in
  - y1_d <= y1_in
  - state <= EMIT_EVEN
- y1_d updates only on accept. Idle gaps do not advance the delay line; it is a block delay, not a cycle delay.
- EMIT_EVEN: data_out=hold_y0, out_phase=0, out_valid=1. Next state is always EMIT_ODD.
- EMIT_ODD: data_out=hold_y1, out_phase=1, out_valid=1.
  - If accept occurs at the end of this cycle, next state is EMIT_EVEN with new hold values. This back-to-back case gives full throughput: 1 block per 2 cycles, continuous out_valid.
  - Otherwise next state is IDLE.
- IDLE: out_valid=0, out_phase=0. data_out holds its last value; it is don't-care but must not be X after reset. Accept moves to EMIT_EVEN.
- Latency: Y0 appears on data_out in the cycle immediately after the accept edge; Y1 appears one cycle later.
- If in_valid is held while in_ready=0 (EMIT_EVEN), the input is ignored. The upstream block must hold its data until accepted.
- out_valid deasserts only by going through IDLE. There is no downstream backpressure: the consumer must take one sample per cycle while out_valid=1.

Test Plan:
- Reset, then idle 5 cycles -> out_valid=0, data_out=0, in_ready=1 throughout.
- Accept (y0=10, y1=3, y01=20) after reset -> next cycle data_out=10 with phase 0; following cycle data_out=7 with phase 1; then out_valid=0.
- Back-to-back: (10,3,20) then (5,−4,1) accepted in the EMIT_ODD cycle -> stream 10, 7, 8, 0 with out_valid continuously 1 for 4 cycles; y1_d carries 3 into the second block's Y0.
- Extremes: y0=y1=−2^31, y01=2^31−1 -> Y0 = −2^31 + y1_d; Y1 = 6442450943, exact in 34 bits. Then the next block (0,0,0) -> Y0 = −2^31, from the delayed y1.
- Stall: in_valid held high with constant data during EMIT_EVEN -> accepted exactly once, at the EMIT_ODD edge; no duplicate samples.
- Assert rst during EMIT_EVEN after block (10,3,20) -> out_valid=0 the next cycle; the following block (0,0,0) yields Y0=0, proving y1_d was cleared.
